i2c_write_engine: RTL and testbench

Byte-serial I2C master that performs one 3-byte write transaction (slave address, register address, data) per request. It sits directly downstream of the codec/video configuration sequencer: the sequencer presents a 24-bit word with a GO level, and this block returns END and ACK. It drives the board I2C pins. It runs entirely on CLOCK_50 with an internal quarter-bit clock enable, so no derived clock is needed.

---
 rtl/i2c_write_engine_if.sv | 12 +
 rtl/i2c_write_engine.sv | 163 ++++++++++++++++
 tb/tb_i2c_write_engine.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/i2c_write_engine_if.sv
// Request/response handshake between the configuration sequencer and the I2C write engine.
// The sequencer side uses the master modport; the engine uses the slave modport.
interface i2c_write_engine_if;
  logic [23:0] I2C_DATA;
  logic        GO;
  logic        END;
  logic        ACK;
  logic        BUSY;

  modport master (output I2C_DATA, output GO, input END, input ACK, input BUSY);
  modport slave  (input I2C_DATA, input GO, output END, output ACK, output BUSY);
endinterface

// File: rtl/i2c_write_engine.sv
// Byte-serial I2C master: one START, three 8-bit bytes each followed by an ack slot, then STOP.
// Everything runs on CLOCK_50; a quarter-bit tick paces every pin and state change.
module i2c_write_engine #(
  parameter int CLK_FREQ = 50000000,
  parameter int I2C_FREQ = 20000
) (
  input  logic                  CLOCK_50,
  input  logic                  iRST_N,
  i2c_write_engine_if.slave     cfg,
  output logic                  I2C_SCLK,
  inout  wire                   I2C_SDAT
);
  localparam int DIV   = CLK_FREQ / (4 * I2C_FREQ);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BIT   = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       q_r;
  logic [3:0]       bit_r;
  logic [1:0]       byte_r;
  logic [23:0]      shift_r;
  logic             acc_r;
  logic             scl_r;
  logic             sda_oe_r;
  logic             end_r;
  logic             ack_r;
  logic             busy_r;

  logic running_s;
  logic tick_s;
  logic ack_slot_s;
  logic sda_in_s;

  assign running_s  = (state_r == START) || (state_r == BIT) || (state_r == STOP);
  assign tick_s     = running_s && (cnt_r == CNT_W'(DIV - 1));
  assign ack_slot_s = (bit_r == 4'd8);
  assign sda_in_s   = I2C_SDAT;

  // Open-drain: the line is only ever pulled low or released.
  assign I2C_SDAT = sda_oe_r ? 1'b0 : 1'bz;
  assign I2C_SCLK = scl_r;
  assign cfg.END  = end_r;
  assign cfg.ACK  = ack_r;
  assign cfg.BUSY = busy_r;

  // Quarter-bit divider, parked at zero whenever no transfer is on the bus.
  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      cnt_r <= '0;
    end else if (!running_s || tick_s) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Transaction FSM with registered bus pins and handshake outputs.
  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      state_r  <= IDLE;
      q_r      <= 2'd0;
      bit_r    <= 4'd0;
      byte_r   <= 2'd0;
      shift_r  <= 24'd0;
      acc_r    <= 1'b0;
      scl_r    <= 1'b1;
      sda_oe_r <= 1'b0;
      end_r    <= 1'b0;
      ack_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cfg.GO) begin
            shift_r <= cfg.I2C_DATA;
            acc_r   <= 1'b0;
            busy_r  <= 1'b1;
            q_r     <= 2'd0;
            bit_r   <= 4'd0;
            byte_r  <= 2'd0;
            state_r <= START;
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          if (tick_s) begin
            if (q_r == 2'd0) begin
              sda_oe_r <= 1'b1;
              q_r      <= 2'd1;
            end else begin
              scl_r   <= 1'b0;
              q_r     <= 2'd0;
              state_r <= BIT;
            end
          end
        end
        BIT: begin
          if (tick_s) begin
            q_r <= q_r + 2'd1;
            case (q_r)
              2'd0: scl_r <= 1'b0;
              2'd1: sda_oe_r <= ack_slot_s ? 1'b0 : ~shift_r[23];
              2'd2: scl_r <= 1'b1;
              default: begin
                // Ack slots sample the slave's answer; a NACK is recorded but never aborts.
                if (ack_slot_s) begin
                  acc_r <= acc_r | sda_in_s;
                  bit_r <= 4'd0;
                  if (byte_r == 2'd2) begin
                    byte_r  <= 2'd0;
                    state_r <= STOP;
                  end else begin
                    byte_r <= byte_r + 2'd1;
                  end
                end else begin
                  shift_r <= {shift_r[22:0], 1'b0};
                  bit_r   <= bit_r + 4'd1;
                end
              end
            endcase
          end
        end
        STOP: begin
          if (tick_s) begin
            q_r <= q_r + 2'd1;
            case (q_r)
              2'd0: scl_r <= 1'b0;
              2'd1: sda_oe_r <= 1'b1;
              2'd2: scl_r <= 1'b1;
              default: begin
                sda_oe_r <= 1'b0;
                end_r    <= 1'b1;
                ack_r    <= acc_r;
                busy_r   <= 1'b0;
                state_r  <= DONE;
              end
            endcase
          end
        end
        DONE: begin
          if (!cfg.GO) begin
            end_r   <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_write_engine.sv
// Bench for i2c_write_engine at DIV=2: bus monitor + acking slave model, vector table and scoreboard.
// Corner sequences cover GO hold after END, mid-transfer reset and data changes after the latch.
module tb_i2c_write_engine;
  localparam int DIV      = 2;
  localparam int TXN_CYC  = 114 * DIV;

  logic CLOCK_50 = 1'b0;
  logic iRST_N   = 1'b0;
  logic i2c_sclk;
  wire  i2c_sdat;

  i2c_write_engine_if bus ();

  i2c_write_engine #(.CLK_FREQ(800), .I2C_FREQ(100)) dut (
    .CLOCK_50 (CLOCK_50),
    .iRST_N   (iRST_N),
    .cfg      (bus),
    .I2C_SCLK (i2c_sclk),
    .I2C_SDAT (i2c_sdat)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Slave model: open-drain on the same line, with a pull-up.
  logic slave_drv = 1'b0;
  logic [2:0] nack_mask = 3'b000;
  pullup (i2c_sdat);
  assign i2c_sdat = slave_drv ? 1'b0 : 1'bz;

  logic sda_s;
  assign sda_s = (i2c_sdat === 1'b0) ? 1'b0 : 1'b1;

  // Bus monitor state.
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  int         starts = 0;
  int         stops  = 0;
  int         bitcnt = 0;
  logic [7:0] shreg  = 8'd0;
  logic [7:0] rx [0:63][0:2];
  int         pos_s;
  int         byte_s;
  assign pos_s  = bitcnt % 9;
  assign byte_s = bitcnt / 9;

  // Decode START/STOP, data bits on SCL rise, and answer ack slots on SCL fall.
  always @(negedge CLOCK_50) begin
    prev_scl <= i2c_sclk;
    prev_sda <= sda_s;
    if (!iRST_N) begin
      slave_drv <= 1'b0;
    end else if (prev_scl && i2c_sclk && prev_sda && !sda_s) begin
      starts <= starts + 1;
      bitcnt <= 0;
    end else if (prev_scl && i2c_sclk && !prev_sda && sda_s) begin
      stops <= stops + 1;
    end else if (!prev_scl && i2c_sclk) begin
      if (pos_s != 8) shreg <= {shreg[6:0], sda_s};
      if (pos_s == 7 && byte_s < 3 && starts > 0 && starts <= 64)
        rx[starts-1][byte_s] <= {shreg[6:0], sda_s};
      bitcnt <= bitcnt + 1;
    end else if (prev_scl && !i2c_sclk) begin
      if (pos_s == 8 && byte_s < 3) slave_drv <= !nack_mask[byte_s];
      else slave_drv <= 1'b0;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [23:0] data;
    logic [2:0]  nack;
    logic        exp_ack;
  } vec_t;

  typedef struct {
    logic [23:0] data;
    logic        exp_ack;
    int          exp_cycles;
  } exp_t;

  exp_t sb_q[$];

  task automatic run_txn(input logic [23:0] data, input logic [2:0] nack,
                         input logic exp_ack, input logic scramble);
    int   n = 0;
    int   fall_n = 0;
    int   end_n = 0;
    int   s0 = starts;
    int   p0 = stops;
    int   idx;
    logic busy_mid = 1'b0;
    exp_t e;
    nack_mask    = nack;
    bus.I2C_DATA = data;
    bus.GO       = 1'b1;
    e.data = data; e.exp_ack = exp_ack; e.exp_cycles = TXN_CYC;
    sb_q.push_back(e);
    while (n < 1000 && end_n == 0) begin
      @(negedge CLOCK_50);
      n++;
      if (fall_n == 0 && !sda_s) fall_n = n;
      if (scramble && n == 20) bus.I2C_DATA = ~data;
      if (n == 50) busy_mid = bus.BUSY;
      if (bus.END) end_n = n;
    end
    check("end_seen", {31'd0, end_n != 0}, 32'd1);
    e = sb_q.pop_front();
    check("sda_fall_delay", fall_n - 1, DIV);
    check("txn_cycles", end_n - 1, e.exp_cycles);
    check("ack", {31'd0, bus.ACK}, {31'd0, e.exp_ack});
    check("busy_mid", {31'd0, busy_mid}, 32'd1);
    check("busy_done", {31'd0, bus.BUSY}, 32'd0);
    repeat (10) @(negedge CLOCK_50);
    check("end_held", {31'd0, bus.END}, 32'd1);
    check("ack_held", {31'd0, bus.ACK}, {31'd0, e.exp_ack});
    check("start_count", starts - s0, 1);
    check("stop_count", stops - p0, 1);
    idx = (starts > 0) ? starts - 1 : 0;
    check("byte0", {24'd0, rx[idx][0]}, {24'd0, e.data[23:16]});
    check("byte1", {24'd0, rx[idx][1]}, {24'd0, e.data[15:8]});
    check("byte2", {24'd0, rx[idx][2]}, {24'd0, e.data[7:0]});
    bus.GO = 1'b0;
    @(negedge CLOCK_50);
    check("end_drop", {31'd0, bus.END}, 32'd0);
  endtask

  vec_t vecs [6];

  initial begin
    int   n;
    logic reached;
    vecs[0] = '{data: 24'h340E4D, nack: 3'b000, exp_ack: 1'b0};
    vecs[1] = '{data: 24'h340E4D, nack: 3'b010, exp_ack: 1'b1};
    vecs[2] = '{data: 24'h40FFFB, nack: 3'b000, exp_ack: 1'b0};
    vecs[3] = '{data: 24'h000000, nack: 3'b100, exp_ack: 1'b1};
    vecs[4] = '{data: 24'hFFFFFF, nack: 3'b111, exp_ack: 1'b1};
    vecs[5] = '{data: 24'hA55AC3, nack: 3'b001, exp_ack: 1'b1};

    bus.GO = 1'b0;
    bus.I2C_DATA = 24'd0;
    repeat (3) @(negedge CLOCK_50);
    check("rst_sclk", {31'd0, i2c_sclk}, 32'd1);
    check("rst_sdat", {31'd0, sda_s}, 32'd1);
    check("rst_end", {31'd0, bus.END}, 32'd0);
    check("rst_ack", {31'd0, bus.ACK}, 32'd0);
    check("rst_busy", {31'd0, bus.BUSY}, 32'd0);
    iRST_N = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].data, vecs[i].nack, vecs[i].exp_ack, (i % 2) == 0);
    end

    // Reset in the middle of slot 10 while SCL is low.
    nack_mask    = 3'b000;
    bus.I2C_DATA = 24'h340E4D;
    bus.GO       = 1'b1;
    n = 0;
    reached = 1'b0;
    while (n < 1000 && !reached) begin
      @(negedge CLOCK_50);
      n++;
      if (bitcnt == 10 && !i2c_sclk) reached = 1'b1;
    end
    check("rst_slot10_reached", {31'd0, reached}, 32'd1);
    check("mid_busy", {31'd0, bus.BUSY}, 32'd1);
    iRST_N = 1'b0;
    #1;
    check("mid_rst_sclk", {31'd0, i2c_sclk}, 32'd1);
    check("mid_rst_sdat", {31'd0, sda_s}, 32'd1);
    check("mid_rst_end", {31'd0, bus.END}, 32'd0);
    check("mid_rst_busy", {31'd0, bus.BUSY}, 32'd0);
    bus.GO = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    iRST_N = 1'b1;
    @(negedge CLOCK_50);
    run_txn(24'h340E4D, 3'b000, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
